mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit with HI/LO registers, attached beside the ALU in the EX stage of the 5-stage pipelined CPU. It takes operands already resolved by EX forwarding, computes MULT/MULTU/DIV/DIVU over 33 cycles, and holds results in HI/LO. MTHI/MTLO write HI/LO directly. `busy` goes to hazard detection so the pipeline stalls on MFHI/MFLO and on a new MDU op while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  EX stage issues an MDU op this cycle; sampled only when `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `a`  in  32  rs operand, post-forwarding; dividend / multiplicand / MTHI/MTLO data.
- `b`  in  32  rt operand, post-forwarding; divisor / multiplier.
- `flush`  in  1  abort the in-flight op; HI/LO keep their old values.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: 32 iterations, 6-bit counter.
  - FIX: sign correction and HI/LO write.
- Edge with `rst`=0: state IDLE, counter 0, `hi`=`lo`=0, `done`=0, internal operands cleared. This applies in any state, including mid-operation.
- IDLE, `start`=1:
  - MULT/DIV (signed): latch |a|, |b| and the sign flags. Result sign = a[31]^b[31]; remainder sign = a[31].
  - MULTU/DIVU: latch the raw operands with sign flags 0.
  - Go to RUN with counter 0.
- IDLE, `start`=1, MTHI/MTLO: `hi` or `lo` = `a` at that edge; stay IDLE; no `done`.
- IDLE, `start`=1, op 110/111: ignored.
- Multiply: radix-2 shift-add, one multiplier bit per RUN edge, into a 64-bit product.
- Divide: restoring division, one quotient bit per RUN edge, into a 33-bit partial remainder.
- RUN, counter=31: next state FIX.
- FIX, multiply:
  - {hi,lo} = product, negated as 64 bits (two's complement) if the result sign is set.
  - Next state IDLE, `done`=1 for the following cycle.
- FIX, divide:
  - `lo` = quotient, negated if the result sign is set.
  - `hi` = remainder, negated if the remainder sign is set.
  - Next state IDLE, `done`=1 for the following cycle.
- Divide by zero (b=0), any signedness: `hi`=a (raw), `lo`=32'hFFFFFFFF, with normal latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: `lo`=32'h80000000, `hi`=0. This falls out of the magnitude path; no special case.
- `start` while `busy`=1: ignored, with no effect on the in-flight op. Hazard detection is required to stall so this never happens.
- `flush`=1 (with `rst`=1): state IDLE, counter 0, `done`=0, HI/LO unchanged. If `flush` and `start` are both high while IDLE, `flush` wins and `start` is ignored.
- `rst` has priority over `flush`; `flush` has priority over `start`.

## Timing
- Edge E0 samples `start` (MULT/DIV family).
- `busy`=1 in the cycles after E0 through E32: 33 cycles.
- RUN edges: E1..E32. FIX edge: E33.
- `hi`/`lo` hold the new value and `done`=1 in the cycle after E33; `busy`=0 in that same cycle. A new `start` is accepted at E34.
- MTHI/MTLO: result visible in the cycle after the sampling edge. `busy` never asserts.
- `hi`/`lo` stay stable during RUN; they change only at FIX, MTHI/MTLO, or reset.
- `done` is registered, never combinational.
- `busy` is a decode of registered state only. It has no combinational path from `start`.

## Test plan
- Reset, then MULT a=32'hFFFFFFFD (-3), b=5 -> after 33 busy cycles, `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFF1, with a one-cycle `done`.
- MULTU a=b=32'hFFFFFFFF -> `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- DIVU a=100, b=7 -> `lo`=14, `hi`=2.
- DIV a=-7, b=2 -> `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
- DIV a=5, b=0 -> `hi`=5, `lo`=32'hFFFFFFFF.
- DIV 32'h80000000 / -1 -> `lo`=32'h80000000, `hi`=0.
- MTHI a=32'h12345678 -> `hi` updated next cycle, `busy` stays 0.
- DIVU, then a second `start` with MULT while busy -> the second op is ignored and the DIVU result is correct.
- MTLO 7, then MULT with `flush` asserted at cycle 10 -> `busy` drops next cycle, `lo`=7, no `done`.
- MULT, then `rst`=0 at cycle 10 -> the next cycle has `busy`=0 and `hi`=`lo`=0.

Source files
------------

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// MULT/MULTU/DIV/DIVU take 33 busy cycles; MTHI/MTLO write HI/LO in one edge.
module mdu (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic        is_div;
   logic        res_neg;
   logic        rem_neg;
   logic        div_zero;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [63:0] prod;
   logic [31:0] rem;

   logic        sgn;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic        fits;

   always_comb begin
      sgn     = ~op[0];
      mag_a   = (sgn && a[31]) ? -a : a;
      mag_b   = (sgn && b[31]) ? -b : b;
      mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opb} : '0);
      // prod[31:0] doubles as the dividend/quotient shift register when dividing
      rem_sh  = {rem, prod[31]};
      rem_sub = rem_sh - {1'b0, opb};
      fits    = ~rem_sub[32];
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         opa      <= '0;
         opb      <= '0;
         prod     <= '0;
         rem      <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (!op[2]) begin
                     is_div   <= op[1];
                     res_neg  <= sgn & (a[31] ^ b[31]);
                     rem_neg  <= sgn & a[31];
                     div_zero <= (b == '0);
                     opa      <= a;
                     opb      <= op[1] ? mag_b : mag_a;
                     prod     <= {32'd0, op[1] ? mag_a : mag_b};
                     rem      <= '0;
                     cnt      <= '0;
                     state    <= S_RUN;
                  end else if (op == 3'b100) begin
                     hi <= a;
                  end else if (op == 3'b101) begin
                     lo <= a;
                  end
               end
            end
            S_RUN: begin
               if (is_div) begin
                  rem  <= fits ? rem_sub[31:0] : rem_sh[31:0];
                  prod <= {32'd0, prod[30:0], fits};
               end else begin
                  prod <= {mul_sum, prod[31:1]};
               end
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  if (div_zero) begin
                     hi <= opa;
                     lo <= '1;
                  end else begin
                     lo <= res_neg ? -prod[31:0] : prod[31:0];
                     hi <= rem_neg ? -rem : rem;
                  end
               end else begin
                  {hi, lo} <= res_neg ? -prod : prod;
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pairs are queued at issue and
// compared by an independent monitor whenever done pulses.
module tb_mdu;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int passes = 0;
   logic [63:0] exp_q[$];

   mdu dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_hi", hi, e[63:32]);
            check("sb_lo", lo, e[31:0]);
         end
      end
   end

   task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int inject, input logic [31:0] hold_hi);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      exp_q.push_back({eh, el});
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 60) begin
         n++;
         if (inject != 0 && n == inject) begin
            check("hold_hi", hi, hold_hi);
            start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", n, 32'd33);
      check("done_pulse", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("done_drop", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      rst = 1'b1;

      // flush beats start in IDLE; no-op opcode is ignored
      @(negedge clk);
      flush = 1'b1; start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
      @(negedge clk);
      flush = 1'b0; op = 3'b110; a = 32'h55555555;
      @(negedge clk);
      start = 1'b0;
      check("flush_start_hi", hi, 32'd0);
      check("noop_busy", {31'd0, busy}, 32'd0);
      check("noop_lo", lo, 32'd0);

      run_md(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, '0);
      run_md(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, '0);
      run_md(3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       0, '0);
      run_md(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, '0);
      run_md(3'b010, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0, '0);
      run_md(3'b011, 32'h89ABCDEF, 32'd0,        32'h89ABCDEF, 32'hFFFFFFFF, 0, '0);
      run_md(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0, '0);
      run_md(3'b000, 32'd7,        32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFC8, 0, '0);

      // MTHI
      @(negedge clk);
      start = 1'b1; op = 3'b100; a = 32'h12345678;
      @(negedge clk);
      start = 1'b0;
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_lo", lo, 32'hFFFFFFC8);
      check("mthi_busy", {31'd0, busy}, 32'd0);

      // second start while busy is ignored
      run_md(3'b011, 32'd1000, 32'd10, 32'd0, 32'd100, 5, 32'h12345678);

      // MTLO then flushed MULT
      @(negedge clk);
      start = 1'b1; op = 3'b101; a = 32'd7;
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
      check("mtlo_lo", lo, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_flush_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_lo", lo, 32'd7);
      check("flush_hi", hi, 32'd0);
      repeat (40) @(negedge clk);
      check("flush_quiet_busy", {31'd0, busy}, 32'd0);

      // reset mid-operation
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
